// File: rtl/spi_master_robot.sv
// ---------------------------------------------------------------------------
// spi_master_robot
//   SPI master (mode 0, MSB first) behind the robot IO register block.
//   Each start pulse runs one full-duplex DATA_W-bit transfer.
//   Software reads the result back as a 32-bit status word.
//
//   Ports:
//     i_clk      system clock, rising edge
//     i_rst      asynchronous active-low reset
//     i_start    one-cycle launch pulse; honoured only when idle
//     i_tx_data  SPI output register; [DATA_W-1:0] are transmitted
//     i_clkdiv   divider register; half-period H = i_clkdiv[DIV_W-1:0] + 1
//     i_miso     serial data from the slave
//     o_sclk     SPI clock, idles low
//     o_mosi     serial data to the slave
//     o_cs_n     active-low chip select
//     o_status   {busy, done, 0..., rx_data[DATA_W-1:0]}
//
//   Build option:
//     SPI_LOOPBACK_EN - when defined, rx samples the driven o_mosi instead
//                       of i_miso (self-test). The pins behave the same.
//
//   The FSM runs one cycle ahead of the pins. Every pin and status bit is a
//   register loaded from the current state. As a result, cs_n/busy change
//   one edge after start is sampled. Done appears one edge after the FSM
//   returns to IDLE.
// ---------------------------------------------------------------------------
module spi_master_robot #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_tx_data,
    input  logic [31:0] i_clkdiv,
    input  logic        i_miso,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_cs_n,
    output logic [31:0] o_status
);

    localparam int BW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              r_state,    w_state;
    logic [DIV_W-1:0]    r_cnt,      w_cnt;
    logic [DIV_W-1:0]    r_hm1,      w_hm1;      // latched H-1
    logic                r_phase_hi, w_phase_hi;
    logic [BW-1:0]       r_bits,     w_bits;     // completed sclk periods
    logic [DATA_W-1:0]   r_tx_sr,    w_tx_sr;
    logic                w_acc, w_fin;

    logic                r_sclk, r_mosi, r_cs_n, r_busy, r_done;
    logic                r_acc, r_fin;
    logic [DATA_W-1:0]   r_rx_sr, r_rx;
    logic                w_sclk, w_mosi, w_sample;

`ifdef SPI_LOOPBACK_EN
    assign w_sample = r_mosi;
    logic w_unused_bits;
    assign w_unused_bits = ^{i_tx_data[31:DATA_W], i_clkdiv[31:DIV_W], i_miso};
`else
    assign w_sample = i_miso;
    logic w_unused_bits;
    assign w_unused_bits = ^{i_tx_data[31:DATA_W], i_clkdiv[31:DIV_W]};
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hm1      <= '0;
            r_phase_hi <= 1'b0;
            r_bits     <= '0;
            r_tx_sr    <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_hm1      <= w_hm1;
            r_phase_hi <= w_phase_hi;
            r_bits     <= w_bits;
            r_tx_sr    <= w_tx_sr;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_hm1      = r_hm1;
        w_phase_hi = r_phase_hi;
        w_bits     = r_bits;
        w_tx_sr    = r_tx_sr;
        w_acc      = 1'b0;
        w_fin      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state = SETUP;
                    w_cnt   = i_clkdiv[DIV_W-1:0];
                    w_hm1   = i_clkdiv[DIV_W-1:0];
                    w_tx_sr = i_tx_data[DATA_W-1:0];
                    w_acc   = 1'b1;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state    = SHIFT;
                    w_cnt      = r_hm1;
                    w_phase_hi = 1'b1;
                    w_bits     = '0;
                end else begin
                    w_cnt = r_cnt - DIV_W'(1);
                end
            end
            SHIFT: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - DIV_W'(1);
                end else if (r_phase_hi) begin
                    // Falling edge: the next tx bit moves into the MSB.
                    w_phase_hi = 1'b0;
                    w_cnt      = r_hm1;
                    w_tx_sr    = {r_tx_sr[DATA_W-2:0], 1'b0};
                end else if (r_bits == BW'(DATA_W - 1)) begin
                    w_state = HOLD;
                    w_cnt   = r_hm1;
                end else begin
                    w_bits     = r_bits + BW'(1);
                    w_phase_hi = 1'b1;
                    w_cnt      = r_hm1;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state = IDLE;
                    w_fin   = 1'b1;
                end else begin
                    w_cnt = r_cnt - DIV_W'(1);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign w_sclk = (r_state == SHIFT) && r_phase_hi;
    assign w_mosi = (r_state != IDLE) ? r_tx_sr[DATA_W-1] : 1'b0;

    // ---------------- pin / status registers ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_acc   <= 1'b0;
            r_fin   <= 1'b0;
            r_rx_sr <= '0;
            r_rx    <= '0;
        end else begin
            r_sclk <= w_sclk;
            r_mosi <= w_mosi;
            r_cs_n <= (r_state == IDLE);
            r_busy <= (r_state != IDLE);
            r_acc  <= w_acc;
            r_fin  <= w_fin;
            // This is the edge on which the pin sclk goes 0->1.
            if (w_sclk && !r_sclk)
                r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_sample};
            if (r_acc)
                r_done <= 1'b0;
            if (r_fin) begin
                r_done <= 1'b1;
                r_rx   <= r_rx_sr;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_cs_n = r_cs_n;

    always_comb begin
        o_status               = '0;
        o_status[DATA_W-1:0]   = r_rx;
        o_status[30]           = r_done;
        o_status[31]           = r_busy;
    end

endmodule
